key_repeat: RTL and testbench

- Consumer end of the debounced push-button path. Takes per-key clean levels from the debouncers and turns them into discrete PRESS, REPEAT (typematic auto-repeat) and RELEASE events.
- Events are serialised onto one valid/ready event port for the game controller, e.g. held left/right keys auto-shift.
- Events that cannot be delivered are coalesced, and an overrun flag is raised.

---
 rtl/key_repeat_pkg.sv | 29 ++
 rtl/key_repeat_if.sv | 10 +
 rtl/key_repeat_chan.sv | 84 ++++++++
 rtl/key_repeat.sv | 83 ++++++++
 tb/tb_key_repeat.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/key_repeat_pkg.sv
// Shared event-type codes, per-key FSM states and pending-bit layout
// for the key auto-repeat path.
package key_pkg;

   localparam logic [1:0] EV_NONE  = 2'b00;
   localparam logic [1:0] EV_PRESS = 2'b01;
   localparam logic [1:0] EV_RPT   = 2'b10;
   localparam logic [1:0] EV_REL   = 2'b11;

   typedef enum logic [1:0] {
      KS_IDLE = 2'd0,
      KS_HOLD = 2'd1,
      KS_RPT  = 2'd2
   } key_state_t;

   // Bit positions inside a key's 3-bit pending vector
   localparam int P_PRESS = 0;
   localparam int P_RPT   = 1;
   localparam int P_REL   = 2;

   // Highest-priority event within one key: press > repeat > release
   function automatic logic [1:0] pend_type(input logic [2:0] pend);
      if (pend[P_PRESS])    return EV_PRESS;
      else if (pend[P_RPT]) return EV_RPT;
      else if (pend[P_REL]) return EV_REL;
      else                  return EV_NONE;
   endfunction

endpackage

// File: rtl/key_repeat_if.sv
// Valid/ready event port carrying key index and event type.
interface key_repeat_if;
   logic       EvValid;
   logic [3:0] EvKey;
   logic [1:0] EvType;
   logic       EvReady;

   modport master (output EvValid, output EvKey, output EvType, input EvReady);
   modport slave  (input EvValid, input EvKey, input EvType, output EvReady);
endinterface

// File: rtl/key_repeat_chan.sv
// One key: edge detect, IDLE/HOLD/RPT typematic FSM and the three
// pending-event bits with coalescing detection.
module key_repeat_chan
   import key_pkg::*;
#(
   parameter int unsigned          CNT_W     = 24,
   parameter logic [CNT_W-1:0]     DELAY_CYC = CNT_W'(5000000),
   parameter logic [CNT_W-1:0]     RATE_CYC  = CNT_W'(1000000)
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       key_clean,
   input  logic       en_repeat,
   input  logic [2:0] clr,
   output logic [2:0] pend,
   output logic       ovr_pulse
);

   localparam logic [CNT_W-1:0] DELAY_TC = DELAY_CYC - CNT_W'(1);
   localparam logic [CNT_W-1:0] RATE_TC  = RATE_CYC - CNT_W'(1);

   logic             prev;
   key_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             rise, fall;
   logic [2:0]       set;

   assign rise = key_clean & ~prev;
   assign fall = ~key_clean & prev;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      set          = '0;
      set[P_PRESS] = rise;
      set[P_REL]   = fall;
      // A release on the same edge as a terminal count suppresses that repeat
      set[P_RPT]   = !fall && en_repeat &&
                     ((state == KS_HOLD && cnt == DELAY_TC) ||
                      (state == KS_RPT  && cnt == RATE_TC));
      ovr_pulse    = |(set & pend & ~clr);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (Rst) begin
         prev  <= 1'b0;
         state <= KS_IDLE;
         cnt   <= '0;
         pend  <= '0;
      end else begin
         prev <= key_clean;
         // Set beats a same-cycle clear: the bit stays pending
         pend <= (pend & ~clr) | set;
         if (fall) begin
            state <= KS_IDLE;
            cnt   <= '0;
         end else begin
            unique case (state)
               KS_IDLE: if (rise) begin
                  state <= KS_HOLD;
                  cnt   <= '0;
               end
               KS_HOLD: if (en_repeat) begin
                  if (cnt == DELAY_TC) begin
                     state <= KS_RPT;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               KS_RPT: if (en_repeat) begin
                  if (cnt == RATE_TC) cnt <= '0;
                  else                cnt <= cnt + CNT_W'(1);
               end
               default: begin
                  state <= KS_IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/key_repeat.sv
// Per-key typematic channels feeding a fixed-priority arbiter and a
// single registered valid/ready event output with sticky overrun.
module key_repeat
   import key_pkg::*;
#(
   parameter int unsigned      NKEYS     = 4,
   parameter int unsigned      CNT_W     = 24,
   parameter logic [CNT_W-1:0] DELAY_CYC = CNT_W'(5000000),
   parameter logic [CNT_W-1:0] RATE_CYC  = CNT_W'(1000000)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [NKEYS-1:0] KeyClean,
   input  logic [NKEYS-1:0] EnRepeat,
   key_repeat_if.master     ev,
   output logic             Overrun
);

   logic [2:0]       pend [NKEYS];
   logic [2:0]       clr  [NKEYS];
   logic [NKEYS-1:0] ovr;
   logic             load, found;
   logic [3:0]       sel_key;
   logic [1:0]       sel_type;

   for (genvar k = 0; k < NKEYS; k++) begin : g_chan
      key_repeat_chan #(
         .CNT_W     (CNT_W),
         .DELAY_CYC (DELAY_CYC),
         .RATE_CYC  (RATE_CYC)
      ) u_chan (
         .Clk       (Clk),
         .Rst       (Rst),
         .key_clean (KeyClean[k]),
         .en_repeat (EnRepeat[k]),
         .clr       (clr[k]),
         .pend      (pend[k]),
         .ovr_pulse (ovr[k])
      );
   end

   // Scan downward so the lowest pending key index wins
   always_comb begin
      found    = 1'b0;
      sel_key  = '0;
      sel_type = EV_NONE;
      for (int k = NKEYS - 1; k >= 0; k--) begin
         if (|pend[k]) begin
            found    = 1'b1;
            sel_key  = 4'(k);
            sel_type = pend_type(pend[k]);
         end
      end
      load = !ev.EvValid || ev.EvReady;
      for (int k = 0; k < NKEYS; k++) begin
         clr[k] = '0;
         if (load && found && sel_key == 4'(k)) begin
            clr[k][P_PRESS] = (sel_type == EV_PRESS);
            clr[k][P_RPT]   = (sel_type == EV_RPT);
            clr[k][P_REL]   = (sel_type == EV_REL);
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ev.EvValid <= 1'b0;
         ev.EvKey   <= '0;
         ev.EvType  <= EV_NONE;
         Overrun    <= 1'b0;
      end else begin
         if (load) begin
            ev.EvValid <= found;
            if (found) begin
               ev.EvKey  <= sel_key;
               ev.EvType <= sel_type;
            end
         end
         Overrun <= Overrun | (|ovr);
      end
   end

endmodule

// File: tb/tb_key_repeat.sv
// Directed bench for key_repeat: table-driven typematic/priority vectors
// plus hand sequences for quick tap, backpressure/overrun and async reset.
module tb_key_repeat;

   localparam logic [1:0] T_NONE  = 2'b00;
   localparam logic [1:0] T_PRESS = 2'b01;
   localparam logic [1:0] T_RPT   = 2'b10;
   localparam logic [1:0] T_REL   = 2'b11;

   logic       Clk = 1'b0;
   logic       Rst;
   logic [3:0] KeyClean;
   logic [3:0] EnRepeat;
   logic       Overrun;
   int         n_cmp = 0;
   int         n_bad = 0;

   key_repeat_if ev_if ();

   key_repeat #(
      .NKEYS     (4),
      .CNT_W     (8),
      .DELAY_CYC (8'd8),
      .RATE_CYC  (8'd4)
   ) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .KeyClean (KeyClean),
      .EnRepeat (EnRepeat),
      .ev       (ev_if.master),
      .Overrun  (Overrun)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [3:0] kc;
      logic [3:0] en;
      logic       rdy;
      logic       v;
      logic [3:0] k;
      logic [1:0] t;
      logic       ovr;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_out(input string name, input logic v, input logic [3:0] k,
                            input logic [1:0] t, input logic ovr);
      check({name, ".valid"}, 8'(ev_if.EvValid), 8'(v));
      if (v) begin
         check({name, ".key"},  8'(ev_if.EvKey),  8'(k));
         check({name, ".type"}, 8'(ev_if.EvType), 8'(t));
      end
      check({name, ".ovr"}, 8'(Overrun), 8'(ovr));
   endtask

   task automatic add(input logic [3:0] kc, input logic [3:0] en, input logic rdy,
                      input logic v, input logic [3:0] k, input logic [1:0] t);
      vec_t x;
      x.kc = kc; x.en = en; x.rdy = rdy; x.v = v; x.k = k; x.t = t; x.ovr = 1'b0;
      vecs.push_back(x);
   endtask

   initial begin
      // Single press with repeat: PRESS@1, RPT@9,13,17, release at edge 20 -> REL@21
      for (int e = 0; e < 24; e++) begin
         case (e)
            1:          add((e < 20) ? 4'b0100 : 4'b0000, 4'b0100, 1'b1, 1'b1, 4'd2, T_PRESS);
            9, 13, 17:  add((e < 20) ? 4'b0100 : 4'b0000, 4'b0100, 1'b1, 1'b1, 4'd2, T_RPT);
            21:         add(4'b0000, 4'b0100, 1'b1, 1'b1, 4'd2, T_REL);
            default:    add((e < 20) ? 4'b0100 : 4'b0000, 4'b0100, 1'b1, 1'b0, 4'd0, T_NONE);
         endcase
      end
      // Same with repeat disabled: only PRESS and RELEASE
      for (int e = 0; e < 24; e++) begin
         case (e)
            1:       add(4'b0100, 4'b0000, 1'b1, 1'b1, 4'd2, T_PRESS);
            21:      add(4'b0000, 4'b0000, 1'b1, 1'b1, 4'd2, T_REL);
            default: add((e < 20) ? 4'b0100 : 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd0, T_NONE);
         endcase
      end
      // Keys 0 and 3 together: lowest index first, for press and for release
      for (int e = 0; e < 9; e++) begin
         case (e)
            1:       add(4'b1001, 4'b0000, 1'b1, 1'b1, 4'd0, T_PRESS);
            2:       add(4'b1001, 4'b0000, 1'b1, 1'b1, 4'd3, T_PRESS);
            6:       add(4'b0000, 4'b0000, 1'b1, 1'b1, 4'd0, T_REL);
            7:       add(4'b0000, 4'b0000, 1'b1, 1'b1, 4'd3, T_REL);
            default: add((e < 5) ? 4'b1001 : 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd0, T_NONE);
         endcase
      end

      // Reset state
      Rst = 1'b1; KeyClean = '0; EnRepeat = '0; ev_if.EvReady = 1'b1;
      tick(); tick();
      check("reset.valid", 8'(ev_if.EvValid), 8'd0);
      check("reset.key",   8'(ev_if.EvKey),   8'd0);
      check("reset.type",  8'(ev_if.EvType),  8'd0);
      check("reset.ovr",   8'(Overrun),       8'd0);
      Rst = 1'b0;
      tick();

      foreach (vecs[i]) begin
         KeyClean = vecs[i].kc; EnRepeat = vecs[i].en; ev_if.EvReady = vecs[i].rdy;
         tick();
         check_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].k, vecs[i].t, vecs[i].ovr);
      end

      // Quick tap under backpressure: press then release both delivered, no overrun
      KeyClean = 4'b0001; EnRepeat = '0; ev_if.EvReady = 1'b0;
      tick(); check_out("tap.e0", 1'b0, 4'd0, T_NONE, 1'b0);
      KeyClean = '0;
      tick(); check_out("tap.e1", 1'b1, 4'd0, T_PRESS, 1'b0);
      tick(); check_out("tap.e2", 1'b1, 4'd0, T_PRESS, 1'b0);
      tick(); check_out("tap.e3", 1'b1, 4'd0, T_PRESS, 1'b0);
      ev_if.EvReady = 1'b1;
      tick(); check_out("tap.rel", 1'b1, 4'd0, T_REL, 1'b0);
      tick(); check_out("tap.idle", 1'b0, 4'd0, T_NONE, 1'b0);

      // Backpressure: key 1 held 20 stalled cycles; repeats at edges 8,12,16 coalesce
      KeyClean = 4'b0010; EnRepeat = 4'b0010; ev_if.EvReady = 1'b0;
      for (int e = 0; e < 20; e++) begin
         tick();
         check_out($sformatf("bp.e%0d", e), (e >= 1), 4'd1, T_PRESS, (e >= 12));
      end
      ev_if.EvReady = 1'b1;
      tick(); check_out("bp.e20", 1'b1, 4'd1, T_RPT, 1'b1);
      tick(); check_out("bp.e21", 1'b1, 4'd1, T_RPT, 1'b1);
      tick(); check_out("bp.e22", 1'b0, 4'd0, T_NONE, 1'b1);
      tick(); check_out("bp.e23", 1'b0, 4'd0, T_NONE, 1'b1);
      tick(); check_out("bp.e24", 1'b0, 4'd0, T_NONE, 1'b1);
      tick(); check_out("bp.e25", 1'b1, 4'd1, T_RPT, 1'b1);

      // Async reset mid-repeat with an event valid: outputs clear without a clock
      #3 Rst = 1'b1;
      #1;
      check("arst.valid", 8'(ev_if.EvValid), 8'd0);
      check("arst.key",   8'(ev_if.EvKey),   8'd0);
      check("arst.type",  8'(ev_if.EvType),  8'd0);
      check("arst.ovr",   8'(Overrun),       8'd0);
      tick(); tick();
      Rst = 1'b0;
      tick(); check_out("arst.r0", 1'b0, 4'd0, T_NONE, 1'b0);
      tick(); check_out("arst.press", 1'b1, 4'd1, T_PRESS, 1'b0);
      KeyClean = '0;
      tick(); check_out("arst.r2", 1'b0, 4'd0, T_NONE, 1'b0);
      tick(); check_out("arst.rel", 1'b1, 4'd1, T_REL, 1'b0);
      tick(); check_out("arst.idle", 1'b0, 4'd0, T_NONE, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
